// File: rtl/spi_master_arbiter_if.sv
// Requester and SPI pin bundle for spi_master_arbiter; "slave" is the arbiter's view.
// Latency: none (wires only).
// Backpressure: none; requesters hold req until their done pulse.
interface spi_master_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int N_SLV = 4,
    parameter int SLV_W = 2
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*SLV_W-1:0] req_slv;
    logic [N_REQ*8-1:0]     req_data;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic [7:0]             rx_data;
    logic                   busy;
    logic                   sclk;
    logic [N_SLV-1:0]       cs_n;
    logic                   mosi;
    logic                   miso;

    modport master (
        output req, req_slv, req_data, miso,
        input  grant, done, rx_data, busy, sclk, cs_n, mosi
    );

    modport slave (
        input  req, req_slv, req_data, miso,
        output grant, done, rx_data, busy, sclk, cs_n, mosi
    );
endinterface

// File: rtl/spi_master_arbiter.sv
// Arbitrates N_REQ requesters onto one mode-0 SPI master, one 8-bit frame per cs_n; SPI_ARB_RR_EN selects round-robin.
// Latency: IDLE+ARB, then cs_n low 18*CLK_DIV cycles; done pulses in the first of CS_GAP gap cycles.
// Backpressure: req is a level held until done; losers wait, the frame runs to completion once granted.
module spi_master_arbiter #(
    parameter int N_REQ   = 4,
    parameter int N_SLV   = 4,
    parameter int SLV_W   = 2,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    spi_master_arbiter_if.slave bus
);

    localparam int IW  = $clog2(N_REQ);
    localparam int CMX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW  = $clog2(CMX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_SLV-1:0] cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             busy_q, busy_d;

    logic [IW-1:0]    win_idx;
    logic             win_vld;
    logic [SLV_W-1:0] win_slv;
    logic [7:0]       win_dat;

`ifdef SPI_ARB_RR_EN
    logic [IW-1:0]    ptr_q, ptr_d;
`endif

    // Search starts at the pointer (round-robin) or at requester 0 (fixed priority).
    always_comb begin
        int base;
        win_idx = '0;
        win_vld = 1'b0;
`ifdef SPI_ARB_RR_EN
        base = int'(ptr_q);
`else
        base = 0;
`endif
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_vld && bus.req[(base + k) % N_REQ]) begin
                win_vld = 1'b1;
                win_idx = IW'((base + k) % N_REQ);
            end
        end
    end

    assign win_slv = bus.req_slv[int'(win_idx)*SLV_W +: SLV_W];
    assign win_dat = bus.req_data[int'(win_idx)*8 +: 8];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        grant_d   = grant_q;
        done_d    = '0;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
`ifdef SPI_ARB_RR_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|bus.req) state_d = S_ARB;
            end
            S_ARB: begin
                cnt_d = '0;
                if (!win_vld) begin
                    state_d = S_IDLE;
                end else begin
                    tx_d  = win_dat;
                    rx_d  = '0;
                    bit_d = '0;
`ifdef SPI_ARB_RR_EN
                    ptr_d = IW'((int'(win_idx) + 1) % N_REQ);
`endif
                    if (int'(win_slv) < N_SLV) begin
                        state_d = S_SETUP;
                        grant_d = N_REQ'(1) << win_idx;
                        mosi_d  = win_dat[7];
                        for (int j = 0; j < N_SLV; j++) cs_n_d[j] = (j != int'(win_slv));
                    end else begin
                        // No such slave: skip the bus entirely and report an empty byte.
                        state_d   = S_GAP;
                        done_d    = N_REQ'(1) << win_idx;
                        rx_data_d = 8'h00;
                    end
                end
            end
            S_SETUP: begin
                mosi_d = tx_q[7];
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[6:0], bus.miso};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_q != 3'd7) begin
                            mosi_d = tx_q[6];
                            tx_d   = {tx_q[6:0], 1'b0};
                        end
                    end else if (bit_q == 3'd7) begin
                        state_d = S_HOLD;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], bus.miso};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d     = '0;
                    state_d   = S_GAP;
                    cs_n_d    = '1;
                    grant_d   = '0;
                    done_d    = grant_q;
                    rx_data_d = rx_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(CS_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= 8'h00;
            grant_q   <= '0;
            done_q    <= '0;
            cs_n_q    <= '1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SPI_ARB_RR_EN
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
`ifdef SPI_ARB_RR_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign bus.grant   = grant_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
    assign bus.busy    = busy_q;
    assign bus.sclk    = sclk_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Randomized scoreboard bench for spi_master_arbiter with a behavioural SPI slave per cs_n line.
module tb_spi_master_arbiter;
    localparam int N_REQ   = 4;
    localparam int N_SLV   = 3;
    localparam int SLV_W   = 2;
    localparam int CLK_DIV = 4;
    localparam int CS_GAP  = 2;
    localparam int LOW_CYC = 18 * CLK_DIV;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    spi_master_arbiter_if #(.N_REQ(N_REQ), .N_SLV(N_SLV), .SLV_W(SLV_W)) ifc ();

    spi_master_arbiter #(
        .N_REQ(N_REQ), .N_SLV(N_SLV), .SLV_W(SLV_W), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(ifc.slave)
    );

    typedef struct {
        int         id;
        int         slv;
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] resp[N_SLV];
    logic [7:0] plan_dat[N_REQ][2];
    int         plan_slv[N_REQ][2];
    int         plan_n[N_REQ];
    int         ptr_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < N_REQ; i++) plan_n[i] = 0;
    endtask

    // Reference: replay the arbitration rule over the set of outstanding frames.
    task automatic predict();
        int   rem[N_REQ];
        int   fi[N_REQ];
        int   w;
        exp_t e;
        for (int i = 0; i < N_REQ; i++) begin
            rem[i] = plan_n[i];
            fi[i]  = 0;
        end
        forever begin
            w = -1;
`ifdef SPI_ARB_RR_EN
            for (int k = 0; k < N_REQ; k++)
                if (w < 0 && rem[(ptr_m + k) % N_REQ] > 0) w = (ptr_m + k) % N_REQ;
            if (w >= 0) ptr_m = (w + 1) % N_REQ;
`else
            for (int j = 0; j < N_REQ; j++)
                if (w < 0 && rem[j] > 0) w = j;
`endif
            if (w < 0) break;
            e.id  = w;
            e.slv = plan_slv[w][fi[w]];
            e.tx  = plan_dat[w][fi[w]];
            e.rx  = (e.slv < N_SLV) ? resp[e.slv] : 8'h00;
            exp_q.push_back(e);
            fi[w]++;
            rem[w]--;
        end
    endtask

    // Requester agents: reload on done, scramble inputs while granted, optionally drop req mid-frame.
    task automatic run_round(input bit drop);
        int fi[N_REQ];
        int cyc;
        predict();
        for (int i = 0; i < N_REQ; i++) begin
            fi[i] = 0;
            if (plan_n[i] > 0) begin
                ifc.req_data[i*8 +: 8]        = plan_dat[i][0];
                ifc.req_slv[i*SLV_W +: SLV_W] = SLV_W'(plan_slv[i][0]);
                ifc.req[i]                    = 1'b1;
            end
        end
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N_REQ; i++) begin
                if (ifc.done[i]) begin
                    fi[i]++;
                    if (fi[i] >= plan_n[i]) begin
                        ifc.req[i] = 1'b0;
                    end else begin
                        ifc.req_data[i*8 +: 8]        = plan_dat[i][fi[i]];
                        ifc.req_slv[i*SLV_W +: SLV_W] = SLV_W'(plan_slv[i][fi[i]]);
                    end
                end else if (ifc.grant[i] && fi[i] < plan_n[i]) begin
                    ifc.req_data[i*8 +: 8]        = ~plan_dat[i][fi[i]];
                    ifc.req_slv[i*SLV_W +: SLV_W] = SLV_W'(~plan_slv[i][fi[i]]);
                    if (drop && fi[i] == plan_n[i] - 1) ifc.req[i] = 1'b0;
                end
            end
            if (ifc.req == '0 && !ifc.busy && exp_q.size() == 0) break;
            if (cyc > 3000) begin
                checks++;
                errors++;
                $display("FAIL round_timeout pending=%0d required=0", exp_q.size());
                exp_q.delete();
                ifc.req = '0;
                break;
            end
        end
    endtask

    // Monitor + slave model: captures each frame from the pins and scores it on done.
    initial begin
        logic             sclk_p;
        logic [N_SLV-1:0] cs_p;
        int               cap_low, cap_rise, cap_slv, nlow, act, sbit, busy_low, cs_high;
        logic [7:0]       cap_mosi;
        bit               multi, twog, b2b, seen_cs;
        exp_t             e;
        sclk_p = 1'b0; cs_p = '1; cap_low = 0; cap_rise = 0; cap_slv = -1; cap_mosi = '0;
        multi = 0; twog = 0; b2b = 0; seen_cs = 0; busy_low = 0; cs_high = 0; sbit = 7;
        ifc.miso = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                sclk_p = 1'b0; cs_p = '1; cap_low = 0; cap_rise = 0; cap_slv = -1; cap_mosi = '0;
                multi = 0; twog = 0; b2b = 0; seen_cs = 0; busy_low = 0; cs_high = 0;
                ifc.miso = 1'b0;
                continue;
            end
            nlow = N_SLV - $countones(ifc.cs_n);
            if ($countones(ifc.grant) > 1) twog = 1;
            if (|ifc.done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=%b required=none", ifc.done);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_onehot", 32'(ifc.done), 32'(1) << e.id);
                    chk("rx_data", 32'(ifc.rx_data), 32'(e.rx));
                    chk("grant_drop", 32'(ifc.grant), 32'd0);
                    chk("cs_released", 32'(ifc.cs_n), 32'((1 << N_SLV) - 1));
                    chk("slave_sel", cap_slv, (e.slv < N_SLV) ? e.slv : -1);
                    chk("cs_low_cycles", cap_low, (e.slv < N_SLV) ? LOW_CYC : 0);
                    chk("sclk_rises", cap_rise, (e.slv < N_SLV) ? 8 : 0);
                    if (e.slv < N_SLV) chk("mosi_byte", 32'(cap_mosi), 32'(e.tx));
                    chk("multi_cs", 32'(multi), 32'd0);
                    chk("multi_grant", 32'(twog), 32'd0);
                    b2b = (exp_q.size() > 0);
                end
                cap_low = 0; cap_rise = 0; cap_slv = -1; cap_mosi = '0; multi = 0; twog = 0;
            end
            if (ifc.busy) begin
                if (busy_low > 0 && b2b) begin
                    chk("busy_gap", busy_low, 1);
                    b2b = 0;
                end
                busy_low = 0;
            end else begin
                busy_low++;
            end
            if (nlow > 0) begin
                act = -1;
                for (int j = 0; j < N_SLV; j++) if (!ifc.cs_n[j] && act < 0) act = j;
                cap_slv = act;
                cap_low++;
                if (nlow > 1) multi = 1;
                if (cs_p == '1) begin
                    if (seen_cs) begin
                        checks++;
                        if (cs_high < CS_GAP + 2) begin
                            errors++;
                            $display("FAIL cs_gap actual=%0d required>=%0d", cs_high, CS_GAP + 2);
                        end
                    end
                    seen_cs  = 1;
                    sbit     = 7;
                    ifc.miso = resp[act][7];
                end else if (!ifc.sclk && sclk_p) begin
                    sbit--;
                    ifc.miso = (sbit >= 0) ? resp[act][sbit] : 1'($urandom);
                end
                cs_high = 0;
            end else begin
                cs_high++;
                ifc.miso = 1'($urandom);
            end
            if (ifc.sclk && !sclk_p) begin
                cap_rise++;
                cap_mosi = {cap_mosi[6:0], ifc.mosi};
            end
            sclk_p = ifc.sclk;
            cs_p   = ifc.cs_n;
        end
    end

    initial begin
        int   r, cyc;
        logic sp;
        ifc.req = '0; ifc.req_slv = '0; ifc.req_data = '0;
        for (int s = 0; s < N_SLV; s++) resp[s] = 8'($urandom);
        clear_plan();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(ifc.grant), 32'd0);
        chk("rst_done", 32'(ifc.done), 32'd0);
        chk("rst_rx_data", 32'(ifc.rx_data), 32'd0);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_sclk", 32'(ifc.sclk), 32'd0);
        chk("rst_cs_n", 32'(ifc.cs_n), 32'((1 << N_SLV) - 1));
        chk("rst_mosi", 32'(ifc.mosi), 32'd0);
        reset_n = 1'b1;
        ptr_m   = 0;
        repeat (2) @(negedge clk);

        // Contention: all four with 0x10..0x13, requester 0 asks twice.
        clear_plan();
        for (int i = 0; i < N_REQ; i++) begin
            plan_n[i] = 1;
            plan_dat[i][0] = 8'h10 + 8'(i);
            plan_slv[i][0] = i % N_SLV;
        end
        plan_n[0] = 2;
        plan_dat[0][1] = 8'h14;
        plan_slv[0][1] = 1;
        run_round(1'b0);

        // Single frame: requester 1 -> slave 2, 0xA5 out, 0x3C back.
        clear_plan();
        resp[2] = 8'h3C;
        plan_n[1] = 1; plan_slv[1][0] = 2; plan_dat[1][0] = 8'hA5;
        run_round(1'b0);

        // Slave index 3 does not exist.
        clear_plan();
        plan_n[2] = 1; plan_slv[2][0] = 3; plan_dat[2][0] = 8'h5A;
        run_round(1'b0);

        // 0xFF latched; the agent flips the input to 0x00 once granted, then drops req.
        clear_plan();
        plan_n[0] = 1; plan_slv[0][0] = 0; plan_dat[0][0] = 8'hFF;
        run_round(1'b1);

        for (int t = 0; t < 20; t++) begin
            clear_plan();
            for (int s = 0; s < N_SLV; s++) resp[s] = 8'($urandom);
            for (int i = 0; i < N_REQ; i++) begin
                plan_n[i] = $urandom_range(0, 2);
                for (int k = 0; k < 2; k++) begin
                    plan_slv[i][k] = $urandom_range(0, 3);
                    plan_dat[i][k] = 8'($urandom);
                end
            end
            if (plan_n[0] + plan_n[1] + plan_n[2] + plan_n[3] == 0) plan_n[$urandom_range(0, 3)] = 1;
            run_round(1'($urandom_range(0, 1)));
        end

        // Reset after the third sclk rise of a frame: everything releases at once, no done.
        @(negedge clk);
        ifc.req_data[0 +: 8]  = 8'hC3;
        ifc.req_slv[0 +: SLV_W] = SLV_W'(1);
        ifc.req[0] = 1'b1;
        r = 0; cyc = 0; sp = ifc.sclk;
        while (r < 3 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (ifc.sclk && !sp) r++;
            sp = ifc.sclk;
        end
        if (r < 3) begin
            checks++;
            errors++;
            $display("FAIL reset_wait_rises actual=%0d required=3", r);
        end
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_cs_n", 32'(ifc.cs_n), 32'((1 << N_SLV) - 1));
        chk("mid_rst_sclk", 32'(ifc.sclk), 32'd0);
        chk("mid_rst_grant", 32'(ifc.grant), 32'd0);
        chk("mid_rst_done", 32'(ifc.done), 32'd0);
        chk("mid_rst_busy", 32'(ifc.busy), 32'd0);
        ifc.req = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        ptr_m   = 0;
        repeat (50) @(negedge clk);
        chk("post_rst_idle", 32'(ifc.busy), 32'd0);

        clear_plan();
        resp[1] = 8'h96;
        plan_n[3] = 1; plan_slv[3][0] = 1; plan_dat[3][0] = 8'h69;
        run_round(1'b0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
Shares one SPI master port between N_REQ on-chip requesters and N_SLV 8-bit SPI slaves (mode 0: sclk idles low, mosi sampled on sclk rise, miso updated on sclk fall). Arbitrates among pending requests, then runs exactly one 8-bit frame per chip-select assertion. Each frame asserts one cs_n low, shifts 8 bits MSB-first, returns the received byte to the winning requester and releases cs_n. Sits between the system-clock domain and the slave bus; sclk is generated from clk.

Parameters:
N_REQ, 4, number of requesters (2..8)
N_SLV, 4, number of slaves / cs_n lines (1..8)
SLV_W, 2, width of slave-select index (clog2 of N_SLV, min 1)
CLK_DIV, 4, clk cycles per sclk half-period (>=2)
CS_GAP, 2, clk cycles cs_n held high between frames (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester transfer request, level, held until done
req_slv  in  N_REQ*SLV_W  per-requester target slave index, slice i = requester i
req_data  in  N_REQ*8  per-requester tx byte, slice i = requester i
grant  out  N_REQ  one-hot, high from arbitration until end of frame
done  out  N_REQ  one-cycle pulse to granted requester at frame end
rx_data  out  8  received byte, valid in the done cycle, held until next done
busy  out  1  high whenever FSM not in IDLE
sclk  out  1  SPI clock
cs_n  out  N_SLV  active-low chip selects, at most one low
mosi  out  1  master data out
miso  in  1  slave data in, may be high-Z (treated as sampled value)

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE; grant=0, done=0, rx_data=8'h00, busy=0, sclk=0, cs_n=all 1, mosi=0; round-robin pointer=0. Reset mid-frame aborts immediately: cs_n rises, no done.
- FSM states: IDLE, ARB, SETUP, SHIFT, HOLD, GAP.
- IDLE: if any req, go to ARB next cycle.
- ARB (1 cycle): pick winner (see Optional Feature); latch req_slv and req_data into internal regs; assert grant[winner]. Later changes to req_* are ignored for this frame.
- Invalid index (latched slave >= N_SLV): no cs_n asserted; go straight to GAP, done pulsed, rx_data=8'h00.
- SETUP: cs_n[slv]=0, mosi=tx[7], sclk=0; lasts CLK_DIV cycles.
- SHIFT: 8 bit periods. Each is CLK_DIV cycles sclk=1 then CLK_DIV cycles sclk=0. miso sampled into rx shift reg in the clk cycle sclk rises. mosi advances to next bit in the cycle sclk falls (not after bit 0). Bit counter 0..7, 3 bits, no wrap beyond 7.
- HOLD: sclk=0, cs_n still low, CLK_DIV cycles.
- cs_n low duration = 18*CLK_DIV clk cycles exactly.
- GAP: cs_n all high; first GAP cycle: done[winner]=1, rx_data updated, grant drops. GAP lasts CS_GAP cycles, then IDLE. Requester holding req high past done is re-arbitrated as a new request.
- req dropped mid-frame: frame completes, done still pulsed.
- Back-to-back: min idle between frames is CS_GAP+1 (IDLE) +1 (ARB) cycles of cs_n high.
- sclk, cs_n, mosi are registered outputs (no glitches).

Optional Feature:
SPI_ARB_RR_EN defined: round-robin; search starts at requester (last_winner+1) mod N_REQ; pointer updates in ARB. Undefined: fixed priority, lowest index wins; pointer logic absent.

Test Plan:
- Single frame: CLK_DIV=4, req[1]=1, req_slv[1]=2, req_data[1]=8'hA5, slave model returns 8'h3C -> cs_n[2] low exactly 72 clk cycles, mosi bits 1,0,1,0,0,1,0,1 at sclk rises, done[1] pulse 1 cycle, rx_data=8'h3C, other cs_n stay high.
- Contention: req=4'b1111 held, bytes 8'h10..8'h13 -> RR build grants order 0,1,2,3,0; fixed build grants 0 repeatedly; never two grant bits high.
- Invalid slave: N_SLV=3, req_slv=3 -> no cs_n low, no sclk edges, done pulsed, rx_data=8'h00.
- Mid-frame reset: assert reset_n=0 after 3rd sclk rise -> cs_n all 1, sclk=0, grant=0 same cycle; no done; next request after release completes normally.
- Input change during frame: change req_data[0] 8'hFF->8'h00 after ARB -> mosi still shifts 8'hFF.
- Gap check: two back-to-back frames, CS_GAP=2 -> cs_n high >= 4 clk cycles between frames, busy low for exactly 1 cycle.
